// File: rtl/semseg_scanner.sv
// semseg_scanner: time-multiplexed driver for common-anode seven-segment banks.
//
// Each digit owns a slot of REFRESH_DIV clock cycles. Slot cycle 0 is a guard
// cycle with every anode off, so the old segment pattern cannot ghost onto the
// next digit. After the guard, the digit is lit while slot_cnt < on_time. The
// brightness code sets on_time, which gives PWM dimming. Digits can be disabled
// one at a time. A digit can also blink: it goes dark while blink_phase is set,
// and blink_phase toggles every BLINK_DIV frames.
//
// Optional feature macro: SEMSEG_SCANNER_LAMP_TEST_EN adds lamp_test_i. While
// lamp_test_i is high, every digit lights all segments for slot cycles
// 1..REFRESH_DIV-1, and the enable, blink and brightness inputs are ignored.
//
// Ports:
//   clk_i        board clock, rising edge
//   rst_i        synchronous active-high reset
//   lamp_test_i  lamp test (only when SEMSEG_SCANNER_LAMP_TEST_EN is defined)
//   segs_i       active-low segment patterns, digit d at [8d+7:8d]
//   digit_en_i   per-digit enable
//   blink_i      per-digit blink select
//   bright_i     brightness code, 0 = dimmest, all ones = full
//   seg_o        active-low segment lines {dp,cg..ca}
//   an_o         active-low anodes, at most one low
//   frame_o      one-cycle pulse after the last slot of each frame
module semseg_scanner #(
    parameter int unsigned DIGITS_NUM   = 8,
    parameter int unsigned REFRESH_DIV  = 1024,
    parameter int unsigned BRIGHT_WIDTH = 3,
    parameter int unsigned BLINK_DIV    = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
`ifdef SEMSEG_SCANNER_LAMP_TEST_EN
    input  logic                      lamp_test_i,
`endif
    input  logic [8*DIGITS_NUM-1:0]   segs_i,
    input  logic [DIGITS_NUM-1:0]     digit_en_i,
    input  logic [DIGITS_NUM-1:0]     blink_i,
    input  logic [BRIGHT_WIDTH-1:0]   bright_i,
    output logic [7:0]                seg_o,
    output logic [DIGITS_NUM-1:0]     an_o,
    output logic                      frame_o
);

    localparam int unsigned SlotW = $clog2(REFRESH_DIV);
    localparam int unsigned DigW  = $clog2(DIGITS_NUM);
    localparam int unsigned FrmW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    // Cycles of on-time per brightness step.
    localparam int unsigned Step  = REFRESH_DIV >> BRIGHT_WIDTH;

    logic [SlotW-1:0]      slot_cnt_q, slot_cnt_d;
    logic [DigW-1:0]       digit_idx_q, digit_idx_d;
    logic [FrmW-1:0]       frame_cnt_q, frame_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS_NUM-1:0] an_q, an_d;
    logic                  frame_q, frame_d;

    logic                  slot_last;
    logic                  digit_last;
    logic                  frame_end;
    logic [SlotW:0]        on_time;
    logic                  lit;
    logic [7:0]            seg_sel;

    // Counter next-state.
    always_comb begin
        slot_cnt_d    = slot_cnt_q + SlotW'(1);
        digit_idx_d   = digit_idx_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;

        slot_last  = (slot_cnt_q == SlotW'(REFRESH_DIV - 1));
        digit_last = (digit_idx_q == DigW'(DIGITS_NUM - 1));
        frame_end  = slot_last && digit_last;

        if (slot_last) begin
            slot_cnt_d  = '0;
            digit_idx_d = digit_last ? '0 : digit_idx_q + DigW'(1);
        end

        if (frame_end) begin
            if (frame_cnt_q == FrmW'(BLINK_DIV - 1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FrmW'(1);
            end
        end
    end

    // Output next-state. on_time is one bit wider than slot_cnt so that full
    // brightness (on_time == REFRESH_DIV) does not overflow.
    always_comb begin
        on_time = ((SlotW + 1)'(bright_i) + (SlotW + 1)'(1)) * (SlotW + 1)'(Step);
        seg_sel = segs_i[{digit_idx_q, 3'b000} +: 8];
        lit     = digit_en_i[digit_idx_q]
                  && !(blink_i[digit_idx_q] && blink_phase_q)
                  && (slot_cnt_q != '0)
                  && ({1'b0, slot_cnt_q} < on_time);
`ifdef SEMSEG_SCANNER_LAMP_TEST_EN
        if (lamp_test_i) begin
            lit     = (slot_cnt_q != '0);
            seg_sel = 8'h00;
        end
`endif
        an_d    = lit ? ~(DIGITS_NUM'(1) << digit_idx_q) : '1;
        seg_d   = lit ? seg_sel : 8'hFF;
        frame_d = frame_end;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= '1;
            seg_q         <= 8'hFF;
            frame_q       <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            digit_idx_q   <= digit_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_q       <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_semseg_scanner.sv
// Bench for semseg_scanner at DIGITS_NUM=4, REFRESH_DIV=16, BRIGHT_WIDTH=2, BLINK_DIV=2.
// A cycle model pushes the expected outputs into a queue before each edge.
// After the edge the bench pops the queue and compares. A table of input
// configurations also gives the expected lit cycles per digit and the expected
// number of frame pulses.
module tb_semseg_scanner;

    localparam int N  = 4;
    localparam int R  = 16;
    localparam int BW = 2;
    localparam int BD = 2;

    logic          clk;
    logic          rst;
    logic [8*N-1:0] segs;
    logic [N-1:0]  en;
    logic [N-1:0]  blink;
    logic [BW-1:0] bright;
    logic [7:0]    seg_o;
    logic [N-1:0]  an_o;
    logic          frame_o;
`ifdef SEMSEG_SCANNER_LAMP_TEST_EN
    logic          lamp;
`endif

    semseg_scanner #(
        .DIGITS_NUM  (N),
        .REFRESH_DIV (R),
        .BRIGHT_WIDTH(BW),
        .BLINK_DIV   (BD)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
`ifdef SEMSEG_SCANNER_LAMP_TEST_EN
        .lamp_test_i(lamp),
`endif
        .segs_i     (segs),
        .digit_en_i (en),
        .blink_i    (blink),
        .bright_i   (bright),
        .seg_o      (seg_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fr;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [3:0]  en;
        logic [3:0]  blink;
        logic [1:0]  bright;
        logic [31:0] segs;
        int          frames;
        int          lit_exp;   // lit cycles for each enabled, non-blinking digit
        int          blink_lit; // lit cycles for blinking digits
        int          pulses;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Model state.
    int m_slot, m_dig, m_frame;
    bit m_phase;

    // Statistics gathered from the DUT outputs.
    int lit_cnt[N];
    int pulses;
    bit saw_b;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) lit_cnt[i] = 0;
        pulses = 0;
        saw_b  = 1'b0;
    endtask

    // One clock: predict, advance the clock, update the model, compare.
    task automatic cycle();
        exp_t e;
        exp_t got;
        bit   on;
        int   on_time;
        e.an  = 4'hF;
        e.seg = 8'hFF;
        e.fr  = 1'b0;
        if (!rst) begin
            on_time = (int'(bright) + 1) * (R / (1 << BW));
            on = en[m_dig] && !(blink[m_dig] && m_phase) && m_slot != 0 && m_slot < on_time;
`ifdef SEMSEG_SCANNER_LAMP_TEST_EN
            if (lamp) on = (m_slot != 0);
`endif
            if (on) begin
                e.an = 4'hF;
                e.an[m_dig] = 1'b0;
                e.seg = segs[m_dig*8 +: 8];
`ifdef SEMSEG_SCANNER_LAMP_TEST_EN
                if (lamp) e.seg = 8'h00;
`endif
            end
            e.fr = (m_dig == N - 1) && (m_slot == R - 1);
        end
        exp_q.push_back(e);

        @(posedge clk);
        #1;

        if (rst) begin
            m_slot = 0; m_dig = 0; m_frame = 0; m_phase = 1'b0;
        end else if (m_slot == R - 1) begin
            m_slot = 0;
            if (m_dig == N - 1) begin
                m_dig = 0;
                if (m_frame == BD - 1) begin
                    m_frame = 0;
                    m_phase = !m_phase;
                end else begin
                    m_frame++;
                end
            end else begin
                m_dig++;
            end
        end else begin
            m_slot++;
        end

        got = exp_q.pop_front();
        checks++;
        if ({an_o, seg_o, frame_o} !== got) begin
            failures++;
            $display("FAIL cycle_out: got an=%h seg=%h fr=%b want an=%h seg=%h fr=%b",
                     an_o, seg_o, frame_o, got.an, got.seg, got.fr);
        end

        for (int i = 0; i < N; i++) if (an_o[i] === 1'b0) lit_cnt[i]++;
        if (frame_o === 1'b1) pulses++;
        if (an_o === 4'hB) saw_b = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        rst    = 1'b1;
        segs   = 32'h80_40_20_10;
        en     = 4'hF;
        blink  = 4'h0;
        bright = 2'd3;
`ifdef SEMSEG_SCANNER_LAMP_TEST_EN
        lamp   = 1'b0;
`endif
        m_slot = 0; m_dig = 0; m_frame = 0; m_phase = 1'b0;

        //          en     blink  br    segs           fr lit blit pulses
        vecs[0] = '{4'hF, 4'h0, 2'd3, 32'h80402010, 1, 15, 0,  1};
        vecs[1] = '{4'hF, 4'h0, 2'd0, 32'h80402010, 1, 3,  0,  1};
        vecs[2] = '{4'hF, 4'h0, 2'd1, 32'hC0A0907F, 1, 7,  0,  1};
        vecs[3] = '{4'hB, 4'h0, 2'd3, 32'h80402010, 1, 15, 0,  1};
        vecs[4] = '{4'hF, 4'h1, 2'd3, 32'h80402010, 6, 90, 60, 6};
        vecs[5] = '{4'hF, 4'h0, 2'd2, 32'h01020304, 2, 22, 0,  2};

        // Exact start-up sequence after reset release.
        do_reset();
        chk("reset_an", 32'(an_o), 32'hF);
        chk("reset_seg", 32'(seg_o), 32'hFF);
        chk("reset_frame", 32'(frame_o), 32'h0);
        cycle();
        chk("first_guard_an", 32'(an_o), 32'hF);
        cycle();
        chk("digit0_an", 32'(an_o), 32'hE);
        chk("digit0_seg", 32'(seg_o), 32'h10);

        // Table of configurations, each one starting from reset.
        for (int v = 0; v < 6; v++) begin
            en     = vecs[v].en;
            blink  = vecs[v].blink;
            bright = vecs[v].bright;
            segs   = vecs[v].segs;
            do_reset();
            clear_stats();
            for (int c = 0; c < vecs[v].frames * N * R + 1; c++) cycle();
            for (int d = 0; d < N; d++) begin
                int want;
                want = !vecs[v].en[d] ? 0 : (vecs[v].blink[d] ? vecs[v].blink_lit
                                                               : vecs[v].lit_exp);
                chk($sformatf("vec%0d_lit_d%0d", v, d), 32'(lit_cnt[d]), 32'(want));
            end
            chk($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(vecs[v].pulses));
            if (v == 3) chk("vec3_no_an_b", 32'(saw_b), 32'h0);
        end

        // Reset in the middle of a scan, at digit 2, slot 7.
        en = 4'hF; blink = 4'h0; bright = 2'd3; segs = 32'h80402010;
        do_reset();
        for (int c = 0; c < 2 * R + 7; c++) cycle();
        chk("mid_pre_an", 32'(an_o), 32'hB);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_an", 32'(an_o), 32'hF);
        chk("mid_rst_seg", 32'(seg_o), 32'hFF);
        chk("mid_rst_frame", 32'(frame_o), 32'h0);
        cycle();
        chk("mid_rel1_an", 32'(an_o), 32'hF);
        cycle();
        chk("mid_rel2_an", 32'(an_o), 32'hE);
        chk("mid_rel2_seg", 32'(seg_o), 32'h10);

        // Brightness change takes effect mid-slot.
        do_reset();
        for (int c = 0; c < 5; c++) cycle();
        bright = 2'd0;
        cycle();
        chk("bright_change_an", 32'(an_o), 32'hF);

`ifdef SEMSEG_SCANNER_LAMP_TEST_EN
        lamp = 1'b1; en = 4'h0; bright = 2'd0; blink = 4'h0;
        do_reset();
        clear_stats();
        for (int c = 0; c < N * R + 1; c++) cycle();
        for (int d = 0; d < N; d++)
            chk($sformatf("lamp_lit_d%0d", d), 32'(lit_cnt[d]), 32'd15);
        lamp = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/semseg_scanner.md
Name: semseg_scanner

Overview:
- Parametrised time-multiplexed driver for common-anode seven-segment display banks.
- Successor to the fixed 8-digit scanner: digit count, refresh period and brightness resolution are parametrised; adds per-digit enable, per-digit blink, PWM dimming and an anti-ghosting blank interval.
- Sits between display-formatting logic (char-to-segment encoders) and the board pins.
- Runs on the 100 MHz board clock.

Parameters:
- DIGITS_NUM, 8, number of digits/anodes (2..16).
- REFRESH_DIV, 1024, clock cycles per digit slot. Power of two, >= 2**BRIGHT_WIDTH.
- BRIGHT_WIDTH, 3, brightness code width.
- BLINK_DIV, 64, number of full scan frames per blink half-period (>= 1).

Ports:
- clk_i  in  1  board clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- segs_i  in  8*DIGITS_NUM  active-low patterns {dp,cg,cf,ce,cd,cc,cb,ca} per digit; digit d = bits [8d+7:8d], driven on an_o[d].
- digit_en_i  in  DIGITS_NUM  1 = digit may light; 0 = digit always dark.
- blink_i  in  DIGITS_NUM  1 = digit is dark during the blink-off phase.
- bright_i  in  BRIGHT_WIDTH  brightness code; 0 = dimmest, all ones = full.
- seg_o  out  8  active-low segment lines {dp,cg..ca}.
- an_o  out  DIGITS_NUM  active-low anodes; at most one bit low at any time.
- frame_o  out  1  one-cycle pulse at the end of each full scan frame.

Behaviour:
- Reset (rst_i high at a clock edge):
  - slot_cnt = 0, digit_idx = 0, frame_cnt = 0, blink_phase = 0 (visible).
  - an_o = all ones, seg_o = 8'hFF, frame_o = 0.
  - Reset mid-scan takes effect at that edge; scanning restarts at digit 0, slot_cnt 0.
- slot_cnt:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, digit_idx increments and wraps from DIGITS_NUM-1 to 0.
- Frame end is the cycle where digit_idx == DIGITS_NUM-1 and slot_cnt == REFRESH_DIV-1. At frame end:
  - frame_cnt increments.
  - When frame_cnt == BLINK_DIV-1, frame_cnt clears and blink_phase toggles.
- Lit condition, evaluated on current counters and current inputs:
  - lit = digit_en_i[digit_idx] && !(blink_i[digit_idx] && blink_phase) && (slot_cnt != 0) && (slot_cnt < on_time).
  - on_time = (bright_i + 1) * (REFRESH_DIV >> BRIGHT_WIDTH), computed at width clog2(REFRESH_DIV)+1 with no overflow.
  - slot_cnt == 0 is the guard cycle: all anodes off, which prevents ghosting on digit change.
- Outputs (all registered, one cycle latency from counters and inputs):
  - an_o = lit ? ~(1 << digit_idx) : all ones.
  - seg_o = lit ? segs_i[digit_idx] : 8'hFF.
  - frame_o = 1 in the cycle after frame end.
- Input changes: segs_i, enables and bright_i may change in any cycle and take effect on the next output register update. There is no frame-boundary latching.
- Full brightness lights cycles 1..REFRESH_DIV-1 of each slot.
- Frame length = DIGITS_NUM*REFRESH_DIV cycles.
- Blink period = 2*BLINK_DIV frames.

Optional Feature:
- Macro: SEMSEG_SCANNER_LAMP_TEST_EN.
- When defined:
  - Extra input lamp_test_i (1 bit) is present.
  - While lamp_test_i is high, lit ignores digit_en_i, blink_i and bright_i: each digit is driven for slot cycles 1..REFRESH_DIV-1 with seg_o = 8'h00.
  - Counters, blink_phase and frame_o are unaffected.
- When not defined: the port and its logic are absent, and behaviour is as above.

Test Plan:
All scenarios use DIGITS_NUM=4, REFRESH_DIV=16, BRIGHT_WIDTH=2, BLINK_DIV=2.
1. Release reset, all enables 1, bright_i=3, segs_i=32'h80_40_20_10 -> an_o=4'hF for first 2 cycles; an_o=4'hE, seg_o=8'h10 for 15 cycles; one blank cycle; then an_o=4'hD, seg_o=8'h20; frame_o pulses every 64 cycles.
2. bright_i=0 -> each digit lit exactly 3 cycles per 16-cycle slot (slot cycles 1..3).
3. digit_en_i=4'b1011 -> an_o never equals 4'hB; seg_o=8'hFF throughout digit 2's slot.
4. blink_i=4'b0001 -> digit 0 lit in frames 0-1, dark in frames 2-3, lit in frames 4-5; other digits lit in every frame.
5. Assert rst_i for 1 cycle while digit_idx=2, slot_cnt=7 -> next cycle an_o=4'hF, seg_o=8'hFF, frame_o=0; digit 0 lit 2 cycles after release.
6. With SEMSEG_SCANNER_LAMP_TEST_EN, lamp_test_i=1, digit_en_i=0, bright_i=0 -> every digit shows seg_o=8'h00 for 15 cycles per slot.
